// File: rtl/ram_multiport.sv
// ram_multiport: parametrised multi-port synchronous RAM with byte-lane
// writes, lowest-port-wins write arbitration with loss reporting, a
// configurable read pipeline and a sequenced clear of the whole array.

// Per-port read pipeline: READ_LATENCY register stages carrying a valid flag
// and the captured word; empty stages hold zero so out_data is 0 when idle.
module ram_multiport_rdpipe #(
  parameter int LAT = 1,
  parameter int W   = 16
) (
  input  logic         in_clk,
  input  logic         in_rst,
  input  logic         in_flush,
  input  logic         in_req,
  input  logic [W-1:0] in_data,
  output logic [W-1:0] out_data,
  output logic         out_valid
);
  logic [LAT:1]        vld_pipe;
  logic [LAT:1][W-1:0] dat_pipe;

  // Shift request/data down the pipe; a flush drops everything in flight.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (in_flush) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_req;
      dat_pipe[1] <= in_req ? in_data : '0;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[LAT];
  assign out_data  = dat_pipe[LAT];
endmodule

module ram_multiport #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_BITS    = 3,
  parameter int WORD_BITS    = 16,
  parameter int BYTE_BITS    = 8,
  parameter int NUM_WORDS    = 2**ADDR_BITS,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  parameter logic [WORD_BITS-1:0] CLEAR_VALUE = '0
) (
  input  logic                                          in_clk,
  input  logic                                          in_rst,
  input  logic                                          in_clear,
  output logic                                          out_busy,
  input  logic [NUM_PORTS-1:0]                          in_read_ena,
  input  logic [NUM_PORTS-1:0]                          in_write_ena,
  input  logic [NUM_PORTS-1:0][WORD_BITS/BYTE_BITS-1:0] in_byte_ena,
  input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0]           in_addr,
  input  logic [NUM_PORTS-1:0][WORD_BITS-1:0]           in_data,
  output logic [NUM_PORTS-1:0][WORD_BITS-1:0]           out_data,
  output logic [NUM_PORTS-1:0]                          out_valid,
  output logic [NUM_PORTS-1:0]                          out_collision
);
  localparam int NUM_LANES = WORD_BITS / BYTE_BITS;
  localparam int AB1       = ADDR_BITS + 1;
  localparam logic [ADDR_BITS:0]   WORDS_W   = AB1'(NUM_WORDS);
  localparam logic [ADDR_BITS-1:0] LAST_WORD = ADDR_BITS'(NUM_WORDS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                               state_q;
  logic [ADDR_BITS-1:0]                 cnt_q;
  logic                                 busy_q;
  logic                                 busy_d;
  logic                                 idle;
  logic [WORD_BITS-1:0]                 mem [NUM_WORDS];
  logic [NUM_PORTS-1:0]                 in_range;
  logic [NUM_PORTS-1:0]                 wr_en;
  logic [NUM_PORTS-1:0]                 rd_en;
  logic [NUM_PORTS-1:0]                 lost_d;
  logic [NUM_PORTS-1:0]                 coll_q;
  logic [NUM_PORTS-1:0][WORD_BITS-1:0]  rd_word;

  assign idle     = (state_q == S_IDLE);
  assign out_busy = busy_q;

  // Busy level after the coming edge; also used to flush read results and
  // collision flags so nothing valid is ever shown while clearing.
  always_comb begin
    busy_d = 1'b0;
    if (state_q == S_CLEAR) busy_d = (cnt_q != LAST_WORD);
    else                    busy_d = in_clear;
  end

  // Clear sequencer: reset lands in CLEAR, one word per edge, back to IDLE
  // on the edge that writes the last word.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (cnt_q == LAST_WORD) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (in_clear) begin
            state_q <= S_CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  // Qualify port requests: nothing is accepted while clearing, and writes
  // past NUM_WORDS are dropped before they can take part in arbitration.
  always_comb begin
    in_range = '0;
    wr_en    = '0;
    rd_en    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_range[p] = ({1'b0, in_addr[p]} < WORDS_W);
      wr_en[p]    = idle & in_write_ena[p] & in_range[p];
      rd_en[p]    = idle & in_read_ena[p];
    end
  end

  // A port loses if any lower-numbered port writes an overlapping lane of
  // the same word in the same cycle.
  always_comb begin
    lost_d = '0;
    for (int p = 1; p < NUM_PORTS; p++)
      for (int q = 0; q < p; q++)
        for (int b = 0; b < NUM_LANES; b++)
          if (wr_en[p] && wr_en[q] && (in_addr[p] == in_addr[q]) &&
              in_byte_ena[p][b] && in_byte_ena[q][b])
            lost_d[p] = 1'b1;
  end

  // Array update: clear word while busy, else byte-lane writes applied from
  // the highest port down so the lowest port's lane is the one that sticks.
  always_ff @(posedge in_clk) begin
    if (state_q == S_CLEAR) begin
      mem[cnt_q] <= CLEAR_VALUE;
    end else begin
      for (int p = NUM_PORTS - 1; p >= 0; p--)
        if (wr_en[p])
          for (int b = 0; b < NUM_LANES; b++)
            if (in_byte_ena[p][b])
              mem[in_addr[p]][b*BYTE_BITS +: BYTE_BITS] <= in_data[p][b*BYTE_BITS +: BYTE_BITS];
    end
  end

  // Read word per port: old contents, or in write-first mode the contents
  // merged with this cycle's arbitrated writes; out of range reads give 0.
  always_comb begin
    rd_word = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (in_range[p]) begin
        rd_word[p] = mem[in_addr[p]];
        if (RDW_MODE != 0) begin
          for (int q = NUM_PORTS - 1; q >= 0; q--)
            if (wr_en[q] && (in_addr[q] == in_addr[p]))
              for (int b = 0; b < NUM_LANES; b++)
                if (in_byte_ena[q][b])
                  rd_word[p][b*BYTE_BITS +: BYTE_BITS] = in_data[q][b*BYTE_BITS +: BYTE_BITS];
        end
      end
    end
  end

  // Collision flags are a single-cycle pulse after the losing write.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) coll_q <= '0;
    else        coll_q <= busy_d ? '0 : lost_d;
  end

  assign out_collision = coll_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    ram_multiport_rdpipe #(
      .LAT (READ_LATENCY),
      .W   (WORD_BITS)
    ) u_rdpipe (
      .in_clk    (in_clk),
      .in_rst    (in_rst),
      .in_flush  (busy_d),
      .in_req    (rd_en[p]),
      .in_data   (rd_word[p]),
      .out_data  (out_data[p]),
      .out_valid (out_valid[p])
    );
  end
endmodule

// File: tb/tb_ram_multiport.sv
// Bench for ram_multiport: two instances share stimulus, one read-first with
// latency 1, one write-first with latency 3; an abstract model predicts both.
module tb_ram_multiport;
  localparam int NP = 2;
  localparam int AB = 3;
  localparam int WB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [NP-1:0]         re = '0;
  logic [NP-1:0]         we = '0;
  logic [NP-1:0][1:0]    be = '0;
  logic [NP-1:0][AB-1:0] addr = '0;
  logic [NP-1:0][WB-1:0] din = '0;

  logic                  busy0, busy1;
  logic [NP-1:0][WB-1:0] q0, q1;
  logic [NP-1:0]         v0, v1, c0, c1;

  int errs = 0;
  int chks = 0;

  always #5 clk = ~clk;

  ram_multiport dut0 (
    .in_clk(clk), .in_rst(rst), .in_clear(clr), .out_busy(busy0),
    .in_read_ena(re), .in_write_ena(we), .in_byte_ena(be), .in_addr(addr),
    .in_data(din), .out_data(q0), .out_valid(v0), .out_collision(c0));

  ram_multiport #(.READ_LATENCY(3), .RDW_MODE(1)) dut1 (
    .in_clk(clk), .in_rst(rst), .in_clear(clr), .out_busy(busy1),
    .in_read_ena(re), .in_write_ena(we), .in_byte_ena(be), .in_addr(addr),
    .in_data(din), .out_data(q1), .out_valid(v1), .out_collision(c1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [WB-1:0]         mmem [8] = '{default: '0};
  bit                    mbusy = 1'b1;
  int                    mcnt = 0;
  int                    cyc = 0;
  logic [NP-1:0]         e0v [8] = '{default: '0};
  logic [NP-1:0]         e1v [8] = '{default: '0};
  logic [NP-1:0]         ecol [8] = '{default: '0};
  logic [NP-1:0][WB-1:0] e0d [8] = '{default: '0};
  logic [NP-1:0][WB-1:0] e1d [8] = '{default: '0};

  task automatic model_step();
    logic [WB-1:0] post [8];
    bit            taken [8][2];
    logic [NP-1:0] lost = '0;
    int a, s0, s2;
    cyc++;
    s0 = cyc % 8;
    s2 = (cyc + 2) % 8;
    if (rst) begin
      mbusy = 1'b1;
      mcnt  = 0;
      for (int i = 0; i < 8; i++) begin
        e0v[i] = '0; e1v[i] = '0; ecol[i] = '0; e0d[i] = '0; e1d[i] = '0;
      end
      return;
    end
    post = mmem;
    if (!mbusy) begin
      for (int p = 0; p < NP; p++)
        if (we[p]) begin
          a = int'(addr[p]);
          for (int b = 0; b < 2; b++)
            if (be[p][b]) begin
              if (taken[a][b]) lost[p] = 1'b1;
              else begin
                taken[a][b] = 1'b1;
                post[a][b*8 +: 8] = din[p][b*8 +: 8];
              end
            end
        end
      for (int p = 0; p < NP; p++)
        if (re[p]) begin
          e0v[s0][p] = 1'b1; e0d[s0][p] = mmem[addr[p]];
          e1v[s2][p] = 1'b1; e1d[s2][p] = post[addr[p]];
        end
      ecol[s0] = lost;
      mmem = post;
      if (clr) begin mbusy = 1'b1; mcnt = 0; end
    end else begin
      mmem[mcnt] = '0;
      if (mcnt == 7) mbusy = 1'b0;
      else           mcnt++;
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- compare ----------------
  always @(negedge clk) begin : cmp
    int s;
    s = cyc % 8;
    chk("busy0", busy0, mbusy);
    chk("busy1", busy1, mbusy);
    chk("valid0", v0, mbusy ? '0 : e0v[s]);
    chk("data0",  q0, mbusy ? '0 : e0d[s]);
    chk("coll0",  c0, mbusy ? '0 : ecol[s]);
    chk("valid1", v1, mbusy ? '0 : e1v[s]);
    chk("data1",  q1, mbusy ? '0 : e1d[s]);
    chk("coll1",  c1, mbusy ? '0 : ecol[s]);
    e0v[s] = '0; e1v[s] = '0; ecol[s] = '0; e0d[s] = '0; e1d[s] = '0;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    re = '0; we = '0; be = '0; clr = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [15:0] d, input logic [1:0] m);
    we[p] = 1'b1; addr[p] = a[AB-1:0]; din[p] = d; be[p] = m;
  endtask

  task automatic rd(input int p, input int a);
    re[p] = 1'b1; addr[p] = a[AB-1:0];
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy0 && n < 50) begin step(); n++; end
  endtask

  logic        t5_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] t5_d [6] = '{16'h0, 16'h0, 16'h1000, 16'h1001, 16'h1002, 16'h0};

  initial begin
    int n;
    idle();
    step(); step();
    chk("rst_busy", busy0, 1);
    chk("rst_valid", {v0, v1}, 0);
    chk("rst_data", q0, 0);
    rst = 1'b0;
    wait_idle(n);
    chk("busy_len", n, 8);

    // reads after clear
    for (int a = 0; a < 8; a++) begin
      idle(); rd(0, a); step();
      chk("t1_valid", v0[0], 1);
      chk("t1_data", q0[0], 16'h0000);
    end
    idle(); step();
    chk("t1_after", v0[0], 0);

    // byte-masked write
    wr(0, 3, 16'h1234, 2'b11); step();
    idle(); wr(0, 3, 16'hABCD, 2'b01); step();
    idle(); rd(0, 3); step();
    chk("t2_d0", q0[0], 16'h12CD);
    idle(); step(); step();
    chk("t2_v1", v1[0], 1);
    chk("t2_d1", q1[0], 16'h12CD);

    // full collision, then disjoint lanes
    idle(); wr(0, 5, 16'h1111, 2'b11); wr(1, 5, 16'h2222, 2'b11); step();
    chk("t3_col0", c0, 2'b10);
    chk("t3_col1", c1, 2'b10);
    idle(); rd(0, 5); step();
    chk("t3_colclr", c0, 0);
    chk("t3_data", q0[0], 16'h1111);
    idle(); wr(0, 5, 16'h1111, 2'b10); wr(1, 5, 16'h2222, 2'b01); step();
    chk("t3b_col", c0, 0);
    idle(); rd(0, 5); step();
    chk("t3b_data", q0[0], 16'h1122);

    // partial overlap: port1 keeps its non-overlapping high lane
    idle(); wr(0, 6, 16'h00AA, 2'b01); wr(1, 6, 16'hBBCC, 2'b11); step();
    chk("ovl_col", c0, 2'b10);
    idle(); rd(1, 6); step();
    chk("ovl_data", q0[1], 16'hBBAA);

    // read during write
    idle(); wr(0, 2, 16'h00AA, 2'b11); step();
    idle(); wr(0, 2, 16'h00BB, 2'b11); rd(1, 2); step();
    chk("t4_old", q0[1], 16'h00AA);
    idle(); step(); step();
    chk("t4_new", q1[1], 16'h00BB);

    // latency 3 back-to-back reads
    idle(); wr(0, 0, 16'h1000, 2'b11); step();
    idle(); wr(0, 1, 16'h1001, 2'b11); step();
    idle(); wr(0, 2, 16'h1002, 2'b11); step();
    idle(); step(); step(); step();
    chk("t5_pre", q1[1], 0);
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 3) rd(1, i);
      step();
      chk("t5_valid", v1[1], t5_v[i]);
      chk("t5_data", q1[1], t5_d[i]);
    end

    // write during clear is ignored
    idle(); wr(0, 4, 16'h4444, 2'b11); step();
    idle(); clr = 1'b1; step();
    chk("t6_busy", busy0, 1);
    idle(); wr(0, 4, 16'hFFFF, 2'b11); step();
    idle();
    wait_idle(n);
    chk("t6_len", n, 7);
    rd(0, 4); step();
    chk("t6_valid", v0[0], 1);
    chk("t6_data", q0[0], 16'h0000);

    // reset drops an in-flight read
    idle(); wr(0, 1, 16'h5A5A, 2'b11); step();
    idle(); rd(1, 1); step();
    idle(); rst = 1'b1; step();
    chk("inflight_v", v1, 0);
    rst = 1'b0;
    wait_idle(n);
    chk("inflight_len", n, 8);

    // reset in the middle of a clear restarts it
    idle(); clr = 1'b1; step();
    idle(); step(); step(); step(); step();
    chk("mid_busy", busy0, 1);
    rst = 1'b1; step();
    rst = 1'b0;
    wait_idle(n);
    chk("mid_len", n, 8);
    idle(); rd(0, 1); step();
    chk("mid_data", q0[0], 16'h0000);
    idle(); step(); step(); step();

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
